// File: rtl/fifo_pkg.sv
// Shared helpers for the width-conversion FIFOs.
package fifo_pkg;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Shift that converts a narrow-word count into a wide-word count.
    function automatic int unsigned nsize_to_sfbit(input int unsigned nsize);
        return clog2(nsize);
    endfunction

    // Only power-of-two ratios up to 16 are supported.
    function automatic bit nsize_legal(input int unsigned nsize);
        return (nsize == 1) || (nsize == 2) || (nsize == 4) || (nsize == 8) || (nsize == 16);
    endfunction

endpackage

// File: rtl/fifo_1ton_mem.sv
// Storage for fifo_1ton: narrow write port, registered wide read port.
module fifo_1ton_mem
    import fifo_pkg::*;
#(
    parameter int unsigned          DSIZE     = 1,
    parameter int unsigned          NSIZE     = 8,
    parameter int unsigned          DEPTH     = 2,
    parameter logic [DSIZE-1:0]     DEF_VALUE = '0,
    localparam int unsigned         WDEPTH    = DEPTH * NSIZE,
    localparam int unsigned         PW        = clog2(WDEPTH),
    localparam int unsigned         RW        = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [PW-1:0]           wr_ptr_i,
    input  logic [DSIZE-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    input  logic [RW-1:0]           rd_ptr_i,
    output logic [DSIZE*NSIZE-1:0]  rd_data_o
);

    localparam int unsigned SFBIT = nsize_to_sfbit(NSIZE);

    logic [DSIZE-1:0]       mem_q [WDEPTH];
    logic [DSIZE*NSIZE-1:0] rd_word;
    logic [DSIZE*NSIZE-1:0] rd_data_q;
    logic [PW-1:0]          rd_base;

    assign rd_base = PW'(rd_ptr_i) << SFBIT;

    // Narrow write into the slot selected by the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WDEPTH); i++) begin
                mem_q[i] <= DEF_VALUE;
            end
        end else if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    // Gather the wide word; oldest narrow word lands in the MSB slice.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < int'(NSIZE); k++) begin
            rd_word[DSIZE*(int'(NSIZE)-1-k) +: DSIZE] = mem_q[rd_base + PW'(k)];
        end
    end

    // Read data only changes on an accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= {NSIZE{DEF_VALUE}};
        end else if (rd_en_i) begin
            rd_data_q <= rd_word;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_1ton.sv
// Width-expanding FIFO: one DSIZE word in per write, NSIZE packed words out per read.
module fifo_1ton
    import fifo_pkg::*;
#(
    parameter int unsigned          DSIZE     = 1,
    parameter int unsigned          NSIZE     = 8,
    parameter int unsigned          DEPTH     = 2,
    parameter int unsigned          ALMOST    = 2,
    parameter logic [DSIZE-1:0]     DEF_VALUE = '0,
    localparam int unsigned         WDEPTH    = DEPTH * NSIZE,
    localparam int unsigned         CSIZE     = clog2(WDEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [DSIZE-1:0]        wr_data_i,
    output logic                    wr_full_o,
    output logic                    wr_almost_full_o,
    output logic [CSIZE-1:0]        wr_count_o,
    input  logic                    rd_en_i,
    output logic [DSIZE*NSIZE-1:0]  rd_data_o,
    output logic                    rd_empty_o,
    output logic                    rd_almost_empty_o,
    output logic [CSIZE-1:0]        rd_count_o,
    output logic                    rd_vld_o
);

    localparam int unsigned SFBIT  = nsize_to_sfbit(NSIZE);
    localparam int unsigned PW     = clog2(WDEPTH);
    localparam int unsigned RW     = clog2(DEPTH);
    localparam int unsigned AF_LVL = WDEPTH - ALMOST * NSIZE;

    if (!nsize_legal(NSIZE)) begin : g_bad_nsize
        $error("fifo_1ton: NSIZE must be 1, 2, 4, 8 or 16");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_1ton: DEPTH must be at least 2");
    end
    if (ALMOST < 1 || ALMOST >= DEPTH) begin : g_bad_almost
        $error("fifo_1ton: ALMOST must satisfy 1 <= ALMOST < DEPTH");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [RW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CSIZE-1:0] cnt_q, cnt_d;
    logic             rd_vld_q;
    logic             wr_acc, rd_acc;

    // Flags are sampled before the edge, so both sides may be accepted together.
    assign wr_acc = wr_en_i && !wr_full_o;
    assign rd_acc = rd_en_i && !rd_empty_o;

    // Next-state for pointers and occupancy; pointers wrap without a step bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(WDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == RW'(DEPTH - 1)) ? '0 : rd_ptr_q + RW'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CSIZE'(1);
            2'b01:   cnt_d = cnt_q - CSIZE'(NSIZE);
            2'b11:   cnt_d = cnt_q + CSIZE'(1) - CSIZE'(NSIZE);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer, occupancy and read-valid state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= rd_acc;
        end
    end

    // Status derived from the registered occupancy only.
    always_comb begin
        wr_count_o        = cnt_q;
        rd_count_o        = cnt_q >> SFBIT;
        wr_full_o         = (cnt_q == CSIZE'(WDEPTH));
        rd_empty_o        = (cnt_q < CSIZE'(NSIZE));
        wr_almost_full_o  = (cnt_q >= CSIZE'(AF_LVL));
        rd_almost_empty_o = (rd_count_o <= CSIZE'(ALMOST));
    end

    assign rd_vld_o = rd_vld_q;

    fifo_1ton_mem #(
        .DSIZE     (DSIZE),
        .NSIZE     (NSIZE),
        .DEPTH     (DEPTH),
        .DEF_VALUE (DEF_VALUE)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_acc),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_acc),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (rd_data_o)
    );

endmodule

// File: tb/tb_fifo_1ton.sv
// Self-checking bench for fifo_1ton against a queue-based reference model.
module tb_fifo_1ton;

    localparam int unsigned DSIZE  = 4;
    localparam int unsigned NSIZE  = 4;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ALMOST = 1;
    localparam int unsigned WDEPTH = DEPTH * NSIZE;
    localparam int unsigned CSIZE  = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   wr_en_i;
    logic [DSIZE-1:0]       wr_data_i;
    logic                   wr_full_o;
    logic                   wr_almost_full_o;
    logic [CSIZE-1:0]       wr_count_o;
    logic                   rd_en_i;
    logic [DSIZE*NSIZE-1:0] rd_data_o;
    logic                   rd_empty_o;
    logic                   rd_almost_empty_o;
    logic [CSIZE-1:0]       rd_count_o;
    logic                   rd_vld_o;

    int n_checks;
    int n_fail;

    // Reference model: narrow words in arrival order plus last read result.
    logic [DSIZE-1:0]       mq [$];
    logic [DSIZE*NSIZE-1:0] m_data;
    logic                   m_vld;

    fifo_1ton #(
        .DSIZE     (DSIZE),
        .NSIZE     (NSIZE),
        .DEPTH     (DEPTH),
        .ALMOST    (ALMOST),
        .DEF_VALUE (4'h0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_en_i           (wr_en_i),
        .wr_data_i         (wr_data_i),
        .wr_full_o         (wr_full_o),
        .wr_almost_full_o  (wr_almost_full_o),
        .wr_count_o        (wr_count_o),
        .rd_en_i           (rd_en_i),
        .rd_data_o         (rd_data_o),
        .rd_empty_o        (rd_empty_o),
        .rd_almost_empty_o (rd_almost_empty_o),
        .rd_count_o        (rd_count_o),
        .rd_vld_o          (rd_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; model advances from its pre-edge state.
    task automatic cycle(input logic we, input logic [DSIZE-1:0] wd, input logic re);
        bit aw, ar;
        wr_en_i   = we;
        wr_data_i = wd;
        rd_en_i   = re;
        aw = we && (mq.size() < int'(WDEPTH));
        ar = re && (mq.size() >= int'(NSIZE));
        @(posedge clk);
        #1;
        if (ar) begin
            for (int k = 0; k < int'(NSIZE); k++) begin
                m_data[DSIZE*(int'(NSIZE)-1-k) +: DSIZE] = mq.pop_front();
            end
        end
        m_vld = ar;
        if (aw) mq.push_back(wd);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
        m_data = '0;
        m_vld  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rd_empty_o, rd_almost_empty_o, wr_full_o, wr_almost_full_o} !== 4'b1100) begin
            $display("FAIL reset_flags: got %b expected 1100",
                     {rd_empty_o, rd_almost_empty_o, wr_full_o, wr_almost_full_o});
            n_fail++;
        end
        n_checks++;
        if (wr_count_o !== 4'd0 || rd_count_o !== 4'd0) begin
            $display("FAIL reset_counts: got wr=%0d rd=%0d expected 0 0", wr_count_o, rd_count_o);
            n_fail++;
        end
        n_checks++;
        if (rd_data_o !== 16'h0000 || rd_vld_o !== 1'b0) begin
            $display("FAIL reset_data: got %h vld=%b expected 0000 vld=0", rd_data_o, rd_vld_o);
            n_fail++;
        end
    endtask

    task automatic test_partial();
        cycle(1'b1, 4'h1, 1'b0);
        cycle(1'b1, 4'h2, 1'b0);
        cycle(1'b1, 4'h3, 1'b1);
        n_checks++;
        if (wr_count_o !== 4'd3 || rd_empty_o !== 1'b1 || rd_vld_o !== 1'b0) begin
            $display("FAIL partial_3: got cnt=%0d empty=%b vld=%b expected 3 1 0",
                     wr_count_o, rd_empty_o, rd_vld_o);
            n_fail++;
        end
        cycle(1'b1, 4'h4, 1'b0);
        n_checks++;
        if (rd_empty_o !== 1'b0 || rd_count_o !== 4'd1) begin
            $display("FAIL partial_4: got empty=%b rd_count=%0d expected 0 1", rd_empty_o, rd_count_o);
            n_fail++;
        end
        cycle(1'b0, 4'h0, 1'b1);
        n_checks++;
        if (rd_data_o !== 16'h1234 || rd_vld_o !== 1'b1) begin
            $display("FAIL partial_read: got %h vld=%b expected 1234 vld=1", rd_data_o, rd_vld_o);
            n_fail++;
        end
        cycle(1'b0, 4'h0, 1'b0);
        n_checks++;
        if (rd_data_o !== 16'h1234 || rd_vld_o !== 1'b0) begin
            $display("FAIL partial_hold: got %h vld=%b expected 1234 vld=0", rd_data_o, rd_vld_o);
            n_fail++;
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 4'(i), 1'b0);
            n_checks++;
            if (wr_almost_full_o !== (i >= 4) || wr_full_o !== (i == 8)) begin
                $display("FAIL full_flags@%0d: got af=%b f=%b expected af=%b f=%b",
                         i, wr_almost_full_o, wr_full_o, (i >= 4), (i == 8));
                n_fail++;
            end
        end
        cycle(1'b1, 4'h9, 1'b0);
        n_checks++;
        if (wr_count_o !== 4'd8 || wr_full_o !== 1'b1) begin
            $display("FAIL full_drop: got cnt=%0d f=%b expected 8 1", wr_count_o, wr_full_o);
            n_fail++;
        end
        cycle(1'b0, 4'h0, 1'b1);
        n_checks++;
        if (rd_data_o !== 16'h1234) begin
            $display("FAIL full_rd0: got %h expected 1234", rd_data_o);
            n_fail++;
        end
        cycle(1'b0, 4'h0, 1'b1);
        n_checks++;
        if (rd_data_o !== 16'h5678 || rd_empty_o !== 1'b1 || rd_vld_o !== 1'b1) begin
            $display("FAIL full_rd1: got %h empty=%b vld=%b expected 5678 1 1",
                     rd_data_o, rd_empty_o, rd_vld_o);
            n_fail++;
        end
    endtask

    task automatic test_simul();
        apply_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 1'b0);
        cycle(1'b1, 4'h6, 1'b1);
        n_checks++;
        if (wr_count_o !== 4'd2 || rd_count_o !== 4'd0 || rd_empty_o !== 1'b1
            || rd_data_o !== 16'h1234) begin
            $display("FAIL simul: got cnt=%0d rc=%0d empty=%b data=%h expected 2 0 1 1234",
                     wr_count_o, rd_count_o, rd_empty_o, rd_data_o);
            n_fail++;
        end
    endtask

    task automatic test_stream();
        logic [DSIZE*NSIZE-1:0] got [$];
        logic [DSIZE*NSIZE-1:0] want [4];
        want[0] = 16'h0123;
        want[1] = 16'h4567;
        want[2] = 16'h89AB;
        want[3] = 16'hCDEF;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            cycle(i < 16, 4'(i), !rd_empty_o);
            if (rd_vld_o) got.push_back(rd_data_o);
            n_checks++;
            if (rd_vld_o !== m_vld || rd_data_o !== m_data || wr_count_o !== CSIZE'(mq.size())) begin
                $display("FAIL stream@%0d: got vld=%b data=%h cnt=%0d expected %b %h %0d",
                         i, rd_vld_o, rd_data_o, wr_count_o, m_vld, m_data, mq.size());
                n_fail++;
            end
        end
        n_checks++;
        if (got.size() != 4) begin
            $display("FAIL stream_count: got %0d words expected 4", got.size());
            n_fail++;
        end
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            n_checks++;
            if (got[j] !== want[j]) begin
                $display("FAIL stream_word%0d: got %h expected %h", j, got[j], want[j]);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        for (int i = 5; i <= 10; i++) cycle(1'b1, 4'(i), 1'b0);
        n_checks++;
        if (wr_count_o !== 4'd6 || rd_data_o !== 16'h1234) begin
            $display("FAIL pre_reset: got cnt=%0d data=%h expected 6 1234", wr_count_o, rd_data_o);
            n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_count_o !== 4'd0 || rd_count_o !== 4'd0 || rd_data_o !== 16'h0000
            || rd_vld_o !== 1'b0 || rd_empty_o !== 1'b1 || rd_almost_empty_o !== 1'b1
            || wr_full_o !== 1'b0 || wr_almost_full_o !== 1'b0) begin
            $display("FAIL async_reset: got cnt=%0d rc=%0d data=%h vld=%b e=%b ae=%b f=%b af=%b",
                     wr_count_o, rd_count_o, rd_data_o, rd_vld_o, rd_empty_o,
                     rd_almost_empty_o, wr_full_o, wr_almost_full_o);
            n_fail++;
        end
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_data = '0;
        m_vld  = 1'b0;
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b1, 4'hC, 1'b0);
        cycle(1'b1, 4'hD, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        n_checks++;
        if (rd_data_o !== 16'hABCD || rd_vld_o !== 1'b1) begin
            $display("FAIL post_reset: got %h vld=%b expected ABCD 1", rd_data_o, rd_vld_o);
            n_fail++;
        end
    endtask

    task automatic test_random();
        int nw;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 4'($urandom), $urandom_range(0, 99) < 30);
            nw = mq.size();
            n_checks++;
            if (wr_count_o !== CSIZE'(nw) || rd_count_o !== CSIZE'(nw / int'(NSIZE))
                || wr_full_o !== (nw == int'(WDEPTH)) || rd_empty_o !== (nw < int'(NSIZE))
                || wr_almost_full_o !== (nw >= int'(WDEPTH - ALMOST * NSIZE))
                || rd_almost_empty_o !== (nw / int'(NSIZE) <= int'(ALMOST))
                || rd_vld_o !== m_vld || rd_data_o !== m_data) begin
                $display("FAIL random@%0d: got cnt=%0d rc=%0d f=%b af=%b e=%b ae=%b vld=%b d=%h expected cnt=%0d vld=%b d=%h",
                         i, wr_count_o, rd_count_o, wr_full_o, wr_almost_full_o, rd_empty_o,
                         rd_almost_empty_o, rd_vld_o, rd_data_o, nw, m_vld, m_data);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        rd_en_i   = 1'b0;
        m_data    = '0;
        m_vld     = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_partial();
        test_full();
        test_simul();
        test_stream();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
